counter_seq_checker: RTL
========================

# counter_seq_checker

Downstream monitor for the 0-to-13 wrap counter. Samples the counter value each qualified cycle, checks that it follows the legal sequence 0,1,…,max_count,0, and emits a one-cycle pulse and a running tally on every wrap. Latches the first illegal value and holds an error flag until software clears it.

## Interface
- number_of_bits, 4: width of the sampled counter value.
- max_count, 13: terminal value; the legal successor of max_count is 0. Must be < 2^number_of_bits.
- wrap_bits, 8: width of the wrap tally.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- count_in  input  number_of_bits  counter value under check.
- count_valid  input  1  count_in is sampled this cycle.
- clear_err  input  1  clears the error state; acts only in ERROR.
- wrap_pulse  output  1  high for one cycle after a legal max_count→0 transition is sampled.
- wrap_count  output  wrap_bits  number of legal wraps seen.
- seq_error  output  1  high while in ERROR.
- err_value  output  number_of_bits  first illegal count_in that caused ERROR.

## Operation
- FSM states: IDLE (no reference sample), TRACK (reference held in prev), ERROR.
- Reset: state=IDLE, prev=0, wrap_pulse=0, wrap_count=0, seq_error=0, err_value=0.
- count_valid=0: state, prev, wrap_count, err_value and seq_error hold; wrap_pulse=0.
- IDLE with valid sample:
  - if count_in ≤ max_count: prev=count_in, go to TRACK; no check, no pulse.
  - else: err_value=count_in, go to ERROR.
- TRACK with valid sample: expected = (prev==max_count) ? 0 : prev+1, computed in number_of_bits.
  - count_in==expected: prev=count_in, stay in TRACK.
  - If additionally prev==max_count: wrap_pulse=1 and wrap_count increments.
  - Any other value, including out-of-range and a repeated value: err_value=count_in, seq_error=1, go to ERROR; no pulse.
- ERROR: all samples ignored; err_value and wrap_count hold.
  - clear_err=1: go to IDLE, seq_error=0, err_value=0.
  - If count_valid is also high that cycle, clear wins and the sample is discarded.
- clear_err in IDLE or TRACK: no effect.
- Reset mid-operation: returns to reset values immediately, regardless of state.

## Timing
- All outputs are registered. A sample taken at edge k is reflected in the outputs after edge k (1-cycle latency).
- wrap_pulse is exactly one cycle wide per legal wrap. Back-to-back pulses are impossible for max_count ≥ 1.
- The seq_error rise and the err_value capture occur in the same cycle.
- seq_error falls one cycle after the edge on which clear_err is sampled in ERROR.
- First legal check occurs on the second valid sample after IDLE.

## Configuration
- COUNTER_CHECK_SAT_EN defined: wrap_count saturates at all-ones and stops incrementing.
- Not defined: wrap_count wraps modulo 2^wrap_bits (all-ones + 1 → 0).
- No other behaviour changes with this macro.

## Structure
- Package counter_check_pkg:
  - state enum typedef (IDLE, TRACK, ERROR).
  - default constants: COUNT_BITS=4, MAX_COUNT=13, WRAP_BITS=8.
- One sub-module, wrap_tally:
  - registered wrap_count with increment enable and async reset.
  - contains the COUNTER_CHECK_SAT_EN saturation logic.
- The FSM, expected-value logic and error capture live in the top module.

## Test plan
- Legal run: reset, then count_valid=1 with 0..13,0..13,0 → two wrap_pulse cycles, wrap_count=2, seq_error=0.
- Skip error: legal 0..5, then 7 → seq_error=1 on the next cycle, err_value=7; further samples leave err_value=7.
- Clear and resync: from ERROR, clear_err=1 with count_valid=1 and count_in=3 → IDLE, seq_error=0, sample dropped. Then 4,5 → no error.
- Stalls and range: count_valid toggled every other cycle during 12,13,0 → exactly one wrap_pulse, no error. Out-of-range 14 in IDLE → ERROR, err_value=14.
- Tally limit: wrap_bits=2, five legal wraps → wrap_count=1 without the macro, 3 with COUNTER_CHECK_SAT_EN.
- Reset mid-TRACK: assert reset between edges → all outputs 0 immediately, next valid sample treated as IDLE.

Source files
------------

// File: rtl/counter_check_pkg.sv
// Shared types and default sizing for the counter sequence checker.
package counter_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam int COUNT_BITS = 4;
    localparam int MAX_COUNT  = 13;
    localparam int WRAP_BITS  = 8;

endpackage

// File: rtl/wrap_tally.sv
// Registered tally of legal wraps. Define COUNTER_CHECK_SAT_EN to saturate at
// all-ones; otherwise the tally wraps modulo 2^wrap_bits.
module wrap_tally
    import counter_check_pkg::*;
#(
    parameter int wrap_bits = WRAP_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [wrap_bits-1:0] wrap_count
);

    logic [wrap_bits-1:0] wrap_count_nx;

    always_comb begin
        wrap_count_nx = wrap_count;
`ifdef COUNTER_CHECK_SAT_EN
        if (inc && (wrap_count != {wrap_bits{1'b1}})) begin
            wrap_count_nx = wrap_count + 1'b1;
        end
`else
        if (inc) begin
            wrap_count_nx = wrap_count + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_count <= '0;
        end else begin
            wrap_count <= wrap_count_nx;
        end
    end

endmodule

// File: rtl/counter_seq_checker.sv
// Monitors a 0..max_count wrap counter: pulses and tallies legal wraps, latches the
// first illegal value. COUNTER_CHECK_SAT_EN selects a saturating wrap tally.
module counter_seq_checker
    import counter_check_pkg::*;
#(
    parameter int number_of_bits = COUNT_BITS,
    parameter int max_count      = MAX_COUNT,
    parameter int wrap_bits      = WRAP_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [number_of_bits-1:0] count_in,
    input  logic                      count_valid,
    input  logic                      clear_err,
    output logic                      wrap_pulse,
    output logic [wrap_bits-1:0]      wrap_count,
    output logic                      seq_error,
    output logic [number_of_bits-1:0] err_value,
    output state_t                    state_dbg
);

    localparam logic [number_of_bits-1:0] MAX_V = number_of_bits'(max_count);

    // count_valid is a qualifier only (no ready): count_in is consumed on every
    // posedge where count_valid is high, and ignored otherwise.
    state_t                    state, state_nx;
    logic [number_of_bits-1:0] prev, prev_nx;
    logic [number_of_bits-1:0] err_nx;
    logic [number_of_bits-1:0] expected;
    logic                      pulse_nx;
    logic                      wrap_inc;

    assign expected  = (prev == MAX_V) ? '0 : prev + 1'b1;
    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        prev_nx  = prev;
        err_nx   = err_value;
        pulse_nx = 1'b0;
        wrap_inc = 1'b0;
        case (state)
            IDLE: begin
                if (count_valid) begin
                    if (count_in <= MAX_V) begin
                        prev_nx  = count_in;
                        state_nx = TRACK;
                    end else begin
                        err_nx   = count_in;
                        state_nx = ERROR;
                    end
                end
            end
            TRACK: begin
                if (count_valid) begin
                    if (count_in == expected) begin
                        prev_nx = count_in;
                        if (prev == MAX_V) begin
                            pulse_nx = 1'b1;
                            wrap_inc = 1'b1;
                        end
                    end else begin
                        err_nx   = count_in;
                        state_nx = ERROR;
                    end
                end
            end
            ERROR: begin
                // Clear takes priority; any sample in the same cycle is dropped.
                if (clear_err) begin
                    err_nx   = '0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            prev       <= '0;
            err_value  <= '0;
            wrap_pulse <= 1'b0;
            seq_error  <= 1'b0;
        end else begin
            state      <= state_nx;
            prev       <= prev_nx;
            err_value  <= err_nx;
            wrap_pulse <= pulse_nx;
            seq_error  <= (state_nx == ERROR);
        end
    end

    wrap_tally #(
        .wrap_bits (wrap_bits)
    ) u_wrap_tally (
        .clk        (clk),
        .reset      (reset),
        .inc        (wrap_inc),
        .wrap_count (wrap_count)
    );

endmodule
